knightrider_decoder: RTL and testbench

Receiving end of the knightrider LED scanner protocol. Samples the 10-bit LED bar (a 2-LED "pair" sliding across a 14-position frame whose window [11:2] is visible). Reconstructs pair position and direction, counts sweep reversals, flags stalls and protocol violations. Sits beside the scanner as an on-board checker, and is reusable for any 10-LED bar-scan source.

---
 rtl/knightrider_decoder_pkg.sv | 26 ++
 rtl/knightrider_decoder_pattern_class.sv | 43 ++++
 rtl/knightrider_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_knightrider_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/knightrider_decoder_pkg.sv
// Shared definitions for the knightrider LED-bar decoder: FSM states, error
// codes, frame geometry and a small adjacency helper.
package knightrider_decoder_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_JUMP    = 2'b10;
    localparam logic [1:0] ERR_REVERSE = 2'b11;

    // 14-position frame; only frame bits [VIS_HI:VIS_LO] reach the LED bar.
    localparam int FRAME_W = 14;
    localparam int VIS_LO  = 2;
    localparam int VIS_HI  = 11;
    localparam int P_MAX   = 12;

    function automatic logic is_adjacent(logic [3:0] a, logic [3:0] b);
        return (a == b + 4'd1) || (b == a + 4'd1);
    endfunction

endpackage

// File: rtl/knightrider_decoder_pattern_class.sv
// Combinational classifier: maps a 10-bit LED pattern to the pair position p
// it represents, or flags it as zero (p = 0 or 12) / illegal.
module knightrider_decoder_pattern_class
    import knightrider_decoder_pkg::*;
(
    input  logic [9:0] pattern,
    output logic [3:0] p,
    output logic       is_zero,
    output logic       legal
);

    logic [8:0] pair_hit;

    // Two adjacent lit LEDs at bar bits k+1,k mean frame bits k+3,k+2.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_pair
            assign pair_hit[gi] = (pattern == (10'd3 << gi));
        end
    endgenerate

    always_comb begin
        p       = 4'd0;
        is_zero = (pattern == 10'd0);
        legal   = 1'b0;
        if (is_zero) begin
            legal = 1'b1;
        end else if (pattern == 10'b00_0000_0001) begin
            legal = 1'b1;
            p     = 4'd1;
        end else if (pattern == 10'b10_0000_0000) begin
            legal = 1'b1;
            p     = 4'(VIS_HI);
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (pair_hit[k]) begin
                    legal = 1'b1;
                    p     = 4'(k + VIS_LO);
                end
            end
        end
    end

endmodule

// File: rtl/knightrider_decoder.sv
// Knightrider LED-bar receiver: locks onto the sliding pair, tracks position
// and direction, counts end-of-travel reversals, detects stalls and faults.
module knightrider_decoder
    import knightrider_decoder_pkg::*;
#(
    parameter int STALL_CYCLES = 2000000,
    parameter int CNT_W        = 22
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic [9:0] LEDin,
    output logic [3:0] position,
    output logic       pos_valid,
    output logic       direction,
    output logic       dir_valid,
    output logic       step,
    output logic [7:0] sweep_count,
    output logic       stalled,
    output logic       error,
    output logic [1:0] error_code
);

    state_t             state_reg, state_next;
    logic [9:0]         in_q_reg;
    logic [9:0]         last_pat_reg, last_pat_next;
    logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
    logic [3:0]         position_reg, position_next;
    logic               pos_valid_reg, pos_valid_next;
    logic               direction_reg, direction_next;
    logic               dir_valid_reg, dir_valid_next;
    logic               step_reg, step_next;
    logic [7:0]         sweep_reg, sweep_next;
    logic               stalled_reg, stalled_next;
    logic               error_reg, error_next;
    logic [1:0]         error_code_reg, error_code_next;

    logic [3:0] cls_p;
    logic       cls_zero;
    logic       cls_legal;

    logic       change;
    logic       cand_ok;
    logic [3:0] cand_p;
    logic       new_dir;
    logic       reversal;
    logic       at_end;
    logic       fault;
    logic [1:0] fault_code;

    knightrider_decoder_pattern_class u_class (
        .pattern (in_q_reg),
        .p       (cls_p),
        .is_zero (cls_zero),
        .legal   (cls_legal)
    );

    assign change = (in_q_reg != last_pat_reg);
    assign at_end = (position_reg == 4'd0) || (position_reg == 4'(P_MAX));

    // A blank bar is ambiguous (p = 0 or 12); the neighbour of the current
    // position decides which end the pair slid off.
    always_comb begin
        cand_ok = 1'b0;
        cand_p  = cls_p;
        if (cls_zero) begin
            if (position_reg == 4'd1) begin
                cand_ok = 1'b1;
                cand_p  = 4'd0;
            end else if (position_reg == 4'(VIS_HI)) begin
                cand_ok = 1'b1;
                cand_p  = 4'(P_MAX);
            end
        end else begin
            cand_ok = is_adjacent(cls_p, position_reg);
        end
    end

    assign new_dir  = (cand_p < position_reg);
    assign reversal = dir_valid_reg && (new_dir != direction_reg);

    always_comb begin
        state_next      = state_reg;
        last_pat_next   = last_pat_reg;
        stall_cnt_next  = stall_cnt_reg;
        position_next   = position_reg;
        pos_valid_next  = pos_valid_reg;
        direction_next  = direction_reg;
        dir_valid_next  = dir_valid_reg;
        step_next       = 1'b0;
        sweep_next      = sweep_reg;
        stalled_next    = stalled_reg;
        error_next      = error_reg;
        error_code_next = error_code_reg;
        fault           = 1'b0;
        fault_code      = ERR_NONE;

        if (change && state_reg != ST_FAULT) begin
            last_pat_next = in_q_reg;
        end

        case (state_reg)
            ST_ACQUIRE: begin
                stall_cnt_next = '0;
                if (change) begin
                    if (!cls_legal) begin
                        fault      = 1'b1;
                        fault_code = ERR_ILLEGAL;
                    end else if (!cls_zero) begin
                        position_next  = cls_p;
                        pos_valid_next = 1'b1;
                        stalled_next   = 1'b0;
                        dir_valid_next = 1'b0;
                        state_next     = ST_TRACK;
                    end
                end
            end

            ST_TRACK: begin
                if (change) begin
                    if (!cls_legal) begin
                        fault      = 1'b1;
                        fault_code = ERR_ILLEGAL;
                    end else if (!cand_ok) begin
                        fault      = 1'b1;
                        fault_code = ERR_JUMP;
                    end else if (reversal && !at_end) begin
                        fault      = 1'b1;
                        fault_code = ERR_REVERSE;
                    end else begin
                        position_next  = cand_p;
                        step_next      = 1'b1;
                        direction_next = new_dir;
                        dir_valid_next = 1'b1;
                        stall_cnt_next = '0;
                        if (reversal) begin
                            sweep_next = sweep_reg + 8'd1;
                        end
                    end
                end else if (stall_cnt_reg == CNT_W'(STALL_CYCLES - 1)) begin
                    stalled_next   = 1'b1;
                    pos_valid_next = 1'b0;
                    dir_valid_next = 1'b0;
                    stall_cnt_next = '0;
                    state_next     = ST_ACQUIRE;
                end else begin
                    stall_cnt_next = stall_cnt_reg + 1'b1;
                end
            end

            default: begin
                // FAULT is terminal until reset; everything is held.
            end
        endcase

        if (fault) begin
            state_next      = ST_FAULT;
            error_next      = 1'b1;
            error_code_next = fault_code;
            pos_valid_next  = 1'b0;
            step_next       = 1'b0;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_reg      <= ST_ACQUIRE;
            in_q_reg       <= '0;
            last_pat_reg   <= '0;
            stall_cnt_reg  <= '0;
            position_reg   <= '0;
            pos_valid_reg  <= 1'b0;
            direction_reg  <= 1'b0;
            dir_valid_reg  <= 1'b0;
            step_reg       <= 1'b0;
            sweep_reg      <= '0;
            stalled_reg    <= 1'b0;
            error_reg      <= 1'b0;
            error_code_reg <= ERR_NONE;
        end else begin
            state_reg      <= state_next;
            in_q_reg       <= LEDin;
            last_pat_reg   <= last_pat_next;
            stall_cnt_reg  <= stall_cnt_next;
            position_reg   <= position_next;
            pos_valid_reg  <= pos_valid_next;
            direction_reg  <= direction_next;
            dir_valid_reg  <= dir_valid_next;
            step_reg       <= step_next;
            sweep_reg      <= sweep_next;
            stalled_reg    <= stalled_next;
            error_reg      <= error_next;
            error_code_reg <= error_code_next;
        end
    end

    assign position    = position_reg;
    assign pos_valid   = pos_valid_reg;
    assign direction   = direction_reg;
    assign dir_valid   = dir_valid_reg;
    assign step        = step_reg;
    assign sweep_count = sweep_reg;
    assign stalled     = stalled_reg;
    assign error       = error_reg;
    assign error_code  = error_code_reg;

endmodule

// File: tb/tb_knightrider_decoder.sv
// Scoreboard bench for knightrider_decoder: expected output snapshots are
// queued with their due cycle when stimulus is driven and checked on arrival.
module tb_knightrider_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] LEDin;
    logic [3:0] position;
    logic       pos_valid, direction, dir_valid, step, stalled, error;
    logic [7:0] sweep_count;
    logic [1:0] error_code;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int step_seen = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [3:0] pos;
        logic       pv;
        logic       dir;
        logic       dv;
        logic       stp;
        logic       stl;
        logic       err;
        logic [1:0] code;
        logic [7:0] sw;
    } exp_t;

    exp_t sb_q[$];

    knightrider_decoder #(.STALL_CYCLES(16), .CNT_W(5)) dut (
        .clkin       (clk),
        .reset       (reset),
        .LEDin       (LEDin),
        .position    (position),
        .pos_valid   (pos_valid),
        .direction   (direction),
        .dir_valid   (dir_valid),
        .step        (step),
        .sweep_count (sweep_count),
        .stalled     (stalled),
        .error       (error),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: compares every snapshot whose due cycle is now.
    always @(negedge clk) begin
        if (step === 1'b1) step_seen++;
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            $display("txn %s cyc=%0d pos=%0d pv=%0b dir=%0b dv=%0b step=%0b stl=%0b err=%0b code=%0d sw=%0d",
                     e.tag, cyc, position, pos_valid, direction, dir_valid, step,
                     stalled, error, error_code, sweep_count);
            check({e.tag, ".pos"},  32'(position),    32'(e.pos));
            check({e.tag, ".pv"},   32'(pos_valid),   32'(e.pv));
            check({e.tag, ".dir"},  32'(direction),   32'(e.dir));
            check({e.tag, ".dv"},   32'(dir_valid),   32'(e.dv));
            check({e.tag, ".step"}, 32'(step),        32'(e.stp));
            check({e.tag, ".stl"},  32'(stalled),     32'(e.stl));
            check({e.tag, ".err"},  32'(error),       32'(e.err));
            check({e.tag, ".code"}, 32'(error_code),  32'(e.code));
            check({e.tag, ".sw"},   32'(sweep_count), 32'(e.sw));
        end
    end

    task automatic expect_at(int offs, string tag, logic [3:0] pos, logic pv, logic dir,
                             logic dv, logic stp, logic stl, logic err, logic [1:0] code,
                             logic [7:0] sw);
        exp_t e;
        e.due = cyc + offs; e.tag = tag; e.pos = pos; e.pv = pv; e.dir = dir; e.dv = dv;
        e.stp = stp; e.stl = stl; e.err = err; e.code = code; e.sw = sw;
        sb_q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(logic [9:0] pat);
        @(negedge clk);
        LEDin = pat;
    endtask

    // One-edge reset; the bar is blanked as reset releases.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        LEDin = 10'd0;
        expect_at(1, "reset", 4'd0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(3);
    endtask

    // Scanner encoder: frame bits p+1,p seen through the window [11:2].
    function automatic logic [9:0] pat_of(int p);
        logic [13:0] frame;
        frame = 14'd3 << p;
        return frame[11:2];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, nsteps, steps_before;
        logic cur_dir, have_dir, nd;
        logic [7:0] sw;
        int targets[4] = '{12, 0, 12, 10};

        reset = 1'b1;
        LEDin = 10'd0;
        idle(2);
        do_reset();

        // Scanner sweep: 2 -> 12 -> 0 -> 12 -> 10, one change per 8 cycles.
        steps_before = step_seen;
        p = 2; nsteps = 0; sw = 8'd0; have_dir = 1'b0; cur_dir = 1'b0;
        drive(pat_of(2));
        expect_at(2, "sweep_lock", 4'd2, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(7);
        foreach (targets[t]) begin
            while (p != targets[t]) begin
                int np;
                np = (targets[t] > p) ? p + 1 : p - 1;
                nd = (np < p);
                if (have_dir && nd != cur_dir) sw++;
                cur_dir = nd; have_dir = 1'b1; p = np; nsteps++;
                drive(pat_of(p));
                expect_at(2, "sweep", 4'(p), 1, nd, 1, 1, 0, 0, 2'd0, sw);
                idle(7);
            end
        end
        check("sweep_steps", 32'(step_seen - steps_before), 32'd36);
        check("sweep_final", 32'(sweep_count), 32'd3);
        check("sweep_err", 32'(error), 32'd0);

        // Lock at 4, step to 5: pulse exactly at edge +2, one cycle wide.
        do_reset();
        drive(10'b00_0000_1100);
        expect_at(2, "lock4", 4'd4, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(7);
        drive(10'b00_0001_1000);
        expect_at(1, "step5_pre",  4'd4, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        expect_at(2, "step5",      4'd5, 1, 0, 1, 1, 0, 0, 2'd0, 8'd0);
        expect_at(3, "step5_post", 4'd5, 1, 0, 1, 0, 0, 0, 2'd0, 8'd0);
        idle(7);

        // Back to 4 while moving up, away from an end: reversal fault, sticky.
        drive(10'b00_0000_1100);
        expect_at(2, "rev_fault", 4'd5, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0);
        idle(7);
        drive(pat_of(6));
        expect_at(2, "fault_hold1", 4'd5, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0);
        idle(7);
        drive(pat_of(5));
        expect_at(2, "fault_hold2", 4'd5, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0);
        idle(7);

        // Non-adjacent jump from 3 to 8.
        do_reset();
        drive(pat_of(3));
        expect_at(2, "lock3", 4'd3, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(7);
        drive(10'b00_1100_0000);
        expect_at(2, "jump_fault", 4'd3, 0, 0, 0, 0, 0, 1, 2'd2, 8'd0);
        idle(7);

        // Illegal pattern while acquiring.
        do_reset();
        drive(10'b00_0000_0101);
        expect_at(2, "illegal", 4'd0, 0, 0, 0, 0, 0, 1, 2'd1, 8'd0);
        idle(7);

        // Stall: expiry 16 edges after lock, then relock via blank and 6.
        do_reset();
        drive(10'b00_0011_0000);
        expect_at(2,  "lock6",     4'd6, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        expect_at(17, "pre_stall", 4'd6, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        expect_at(18, "stall",     4'd6, 0, 0, 0, 0, 1, 0, 2'd0, 8'd0);
        idle(20);
        drive(10'd0);
        expect_at(2, "stall_zero", 4'd6, 0, 0, 0, 0, 1, 0, 2'd0, 8'd0);
        idle(7);
        drive(10'b00_0011_0000);
        expect_at(2, "relock6", 4'd6, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(7);

        // Reset mid-sweep at 11, blank bar must not lock; then relock at 11.
        do_reset();
        drive(pat_of(10));
        expect_at(2, "lock10", 4'd10, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(7);
        drive(pat_of(11));
        expect_at(2, "step11", 4'd11, 1, 0, 1, 1, 0, 0, 2'd0, 8'd0);
        idle(7);
        do_reset();
        expect_at(4, "blank_idle", 4'd0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(7);
        drive(10'b10_0000_0000);
        expect_at(2, "lock11", 4'd11, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        idle(7);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
